// File: rtl/vga_pkg.sv
// Shared types, screen geometry and address helper for the pixel framebuffer.
package vga_pkg;

  localparam int unsigned SCREEN_W = 160;
  localparam int unsigned SCREEN_H = 120;
  localparam int unsigned COLOUR_W = 3;
  localparam int unsigned X_W      = 8;
  localparam int unsigned Y_W      = 7;
  localparam int unsigned ADDR_W   = 15;
  localparam int unsigned FB_DEPTH = SCREEN_W * SCREEN_H;

  typedef logic [COLOUR_W-1:0] colour_t;
  typedef logic [X_W-1:0]      x_t;
  typedef logic [Y_W-1:0]      y_t;
  typedef logic [ADDR_W-1:0]   addr_t;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } fb_state_t;

  localparam addr_t LAST_ADDR = ADDR_W'(FB_DEPTH - 1);
  localparam x_t    LAST_X    = X_W'(SCREEN_W - 1);
  localparam y_t    LAST_Y    = Y_W'(SCREEN_H - 1);

  // y*160 + x without a multiplier: 160 = 128 + 32.
  function automatic addr_t fb_addr(input x_t x, input y_t y);
    return (ADDR_W'(y) << 7) + (ADDR_W'(y) << 5) + ADDR_W'(x);
  endfunction

endpackage

// File: rtl/fb_ram.sv
// Simple dual-port 19200x3 RAM: synchronous write, registered read returning old data on collision.
module fb_ram
  import vga_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  logic    wr_en,
  input  addr_t   wr_addr,
  input  colour_t wr_data,
  input  logic    rd_en,
  input  addr_t   rd_addr,
  output colour_t rd_data
);

  colour_t mem [0:FB_DEPTH-1];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Output register is reset; the array itself is not.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/pixel_framebuffer.sv
// 160x120x3 framebuffer: plot write port, full-screen clear engine and raster scanout.
module pixel_framebuffer
  import vga_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  x_t      vga_x,
  input  y_t      vga_y,
  input  colour_t vga_colour,
  input  logic    vga_plot,
  input  logic    clear_req,
  input  colour_t clear_colour,
  output logic    clear_busy,
  input  logic    scan_en,
  output x_t      pix_x,
  output y_t      pix_y,
  output colour_t pix_colour,
  output logic    pix_valid,
  output logic    frame_start,
  output logic    line_end
);

  fb_state_t state;
  addr_t     clr_addr;
  colour_t   clr_colour;

  x_t        sx;
  y_t        sy;

  logic      plot_ok;
  logic      wr_en;
  addr_t     wr_addr;
  colour_t   wr_data;
  addr_t     rd_addr;

  // Clear engine: one address per cycle, 19200 cycles in CLEAR.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      clr_addr   <= '0;
      clr_colour <= '0;
      clear_busy <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (clear_req) begin
            state      <= CLEAR;
            clr_addr   <= '0;
            clr_colour <= clear_colour;
            clear_busy <= 1'b1;
          end
        end
        CLEAR: begin
          if (clr_addr == LAST_ADDR) begin
            state      <= IDLE;
            clear_busy <= 1'b0;
          end else begin
            clr_addr <= clr_addr + ADDR_W'(1);
          end
        end
        default: begin
          state      <= IDLE;
          clear_busy <= 1'b0;
        end
      endcase
    end
  end

  assign plot_ok = vga_plot && (vga_x < X_W'(SCREEN_W)) && (vga_y < Y_W'(SCREEN_H));

  // Single write port: the clear engine owns it while clearing.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    if (state == CLEAR) begin
      wr_en   = 1'b1;
      wr_addr = clr_addr;
      wr_data = clr_colour;
    end else begin
      wr_en   = plot_ok;
      wr_addr = fb_addr(vga_x, vga_y);
      wr_data = vga_colour;
    end
  end

  assign rd_addr = fb_addr(sx, sy);

  // Scan counters and pixel sidebands, aligned with the one-cycle RAM read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sx          <= '0;
      sy          <= '0;
      pix_x       <= '0;
      pix_y       <= '0;
      pix_valid   <= 1'b0;
      frame_start <= 1'b0;
      line_end    <= 1'b0;
    end else if (scan_en) begin
      pix_x       <= sx;
      pix_y       <= sy;
      pix_valid   <= 1'b1;
      frame_start <= (sx == '0) && (sy == '0);
      line_end    <= (sx == LAST_X);
      if (sx == LAST_X) begin
        sx <= '0;
        sy <= (sy == LAST_Y) ? '0 : sy + Y_W'(1);
      end else begin
        sx <= sx + X_W'(1);
      end
    end else begin
      pix_valid   <= 1'b0;
      frame_start <= 1'b0;
      line_end    <= 1'b0;
    end
  end

  fb_ram u_fb_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_en   (scan_en),
    .rd_addr (rd_addr),
    .rd_data (pix_colour)
  );

endmodule

// File: tb/tb_pixel_framebuffer.sv
// Directed self-checking bench for pixel_framebuffer.
module tb_pixel_framebuffer;

  logic       clk;
  logic       rst_n;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot;
  logic       clear_req;
  logic [2:0] clear_colour;
  logic       clear_busy;
  logic       scan_en;
  logic [7:0] pix_x;
  logic [6:0] pix_y;
  logic [2:0] pix_colour;
  logic       pix_valid;
  logic       frame_start;
  logic       line_end;

  int checks;
  int failures;

  logic [2:0] model [0:19199];
  logic [2:0] cap   [0:19199];
  int ex, ey;
  bit tb_clearing;
  bit check_en;
  int scan_err, fs_cnt, le_cnt, white_cnt;

  pixel_framebuffer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .vga_x        (vga_x),
    .vga_y        (vga_y),
    .vga_colour   (vga_colour),
    .vga_plot     (vga_plot),
    .clear_req    (clear_req),
    .clear_colour (clear_colour),
    .clear_busy   (clear_busy),
    .scan_en      (scan_en),
    .pix_x        (pix_x),
    .pix_y        (pix_y),
    .pix_colour   (pix_colour),
    .pix_valid    (pix_valid),
    .frame_start  (frame_start),
    .line_end     (line_end)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One clock: drive inputs, predict the scanout pixel, then compare after the edge.
  task automatic step(input bit scan, input bit plot, input int px, input int py,
                      input logic [2:0] pc, input bit clr, input logic [2:0] cc);
    bit         ev;
    int         exx, eyy;
    logic [2:0] ecol;
    bit         efs, ele;
    scan_en      = scan;
    vga_plot     = plot;
    vga_x        = 8'(px);
    vga_y        = 7'(py);
    vga_colour   = pc;
    clear_req    = clr;
    clear_colour = cc;
    ev   = scan;
    exx  = ex;
    eyy  = ey;
    ecol = model[eyy * 160 + exx];
    efs  = (ex == 0) && (ey == 0);
    ele  = (ex == 159);
    if (scan) begin
      if (ex == 159) begin
        ex = 0;
        ey = (ey == 119) ? 0 : ey + 1;
      end else begin
        ex = ex + 1;
      end
    end
    if (plot && !tb_clearing && px < 160 && py < 120) model[py * 160 + px] = pc;
    @(posedge clk);
    #1;
    if (check_en) begin
      if (pix_valid !== ev) begin
        scan_err++;
      end else if (ev) begin
        if (pix_x !== 8'(exx) || pix_y !== 7'(eyy) || pix_colour !== ecol ||
            frame_start !== efs || line_end !== ele) scan_err++;
        cap[eyy * 160 + exx] = pix_colour;
        if (frame_start === 1'b1) fs_cnt++;
        if (line_end === 1'b1) le_cnt++;
        if (pix_colour === 3'b111) white_cnt++;
      end else if (frame_start !== 1'b0 || line_end !== 1'b0) begin
        scan_err++;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 3'b000, 0, 3'b000);
  endtask

  task automatic plot1(input int px, input int py, input logic [2:0] pc);
    step(0, 1, px, py, pc, 0, 3'b000);
  endtask

  initial begin
    int busy_cycles;
    int guard;
    checks = 0; failures = 0;
    ex = 0; ey = 0;
    tb_clearing = 0; check_en = 1;
    scan_err = 0; fs_cnt = 0; le_cnt = 0; white_cnt = 0;
    rst_n = 1'b0;
    scan_en = 0; vga_plot = 0; vga_x = '0; vga_y = '0; vga_colour = '0;
    clear_req = 0; clear_colour = '0;
    #2;
    chk("rst_clear_busy", 32'(clear_busy), 0);
    chk("rst_pix_valid", 32'(pix_valid), 0);
    chk("rst_pix_x", 32'(pix_x), 0);
    chk("rst_pix_y", 32'(pix_y), 0);
    chk("rst_pix_colour", 32'(pix_colour), 0);
    chk("rst_frame_start", 32'(frame_start), 0);
    chk("rst_line_end", 32'(line_end), 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // Clear to 000 with a dropped plot and an ignored second clear request.
    step(0, 0, 0, 0, 3'b000, 1, 3'b000);
    tb_clearing = 1;
    busy_cycles = 0;
    while (clear_busy === 1'b1 && busy_cycles < 25000) begin
      busy_cycles++;
      if (busy_cycles == 100)      step(0, 1, 10, 10, 3'b110, 0, 3'b000);
      else if (busy_cycles == 200) step(0, 0, 0, 0, 3'b000, 1, 3'b111);
      else                         idle(1);
    end
    tb_clearing = 0;
    for (int i = 0; i < 19200; i++) model[i] = 3'b000;
    chk("clear_busy_cycles", 32'(busy_cycles), 19200);

    plot1(160, 0, 3'b111);
    plot1(0, 120, 3'b111);
    plot1(80, 60, 3'b010);
    plot1(159, 119, 3'b101);

    // Frame 1: full scan.
    scan_err = 0; fs_cnt = 0; le_cnt = 0; white_cnt = 0;
    for (int i = 0; i < 19200; i++) step(1, 0, 0, 0, 3'b000, 0, 3'b000);
    chk("frame1_scan_errors", 32'(scan_err), 0);
    chk("frame1_frame_start_count", 32'(fs_cnt), 1);
    chk("frame1_line_end_count", 32'(le_cnt), 120);
    chk("frame1_no_111", 32'(white_cnt), 0);
    chk("last_pix_x", 32'(pix_x), 159);
    chk("last_pix_y", 32'(pix_y), 119);
    chk("last_pix_colour", 32'(pix_colour), 32'h5);
    chk("last_line_end", 32'(line_end), 1);
    chk("pix_80_60", 32'(cap[60 * 160 + 80]), 32'h2);
    chk("pix_79_60", 32'(cap[60 * 160 + 79]), 0);
    chk("pix_81_60", 32'(cap[60 * 160 + 81]), 0);
    chk("pix_80_59", 32'(cap[59 * 160 + 80]), 0);
    chk("pix_80_61", 32'(cap[61 * 160 + 80]), 0);
    chk("pix_10_10_dropped", 32'(cap[10 * 160 + 10]), 0);
    chk("pix_0_0", 32'(cap[0]), 0);

    step(1, 0, 0, 0, 3'b000, 0, 3'b000);
    chk("wrap_frame_start", 32'(frame_start), 1);
    chk("wrap_pix_x", 32'(pix_x), 0);
    chk("wrap_pix_y", 32'(pix_y), 0);

    // Collision at (5,5): old data now, new data next frame.
    scan_err = 0;
    guard = 0;
    while (!(ex == 5 && ey == 5) && guard < 20000) begin
      step(1, 0, 0, 0, 3'b000, 0, 3'b000);
      guard++;
    end
    chk("reach_5_5_guard", 32'(guard), 804);
    step(1, 1, 5, 5, 3'b011, 0, 3'b000);
    chk("collision_old_colour", 32'(pix_colour), 0);
    chk("collision_pix_x", 32'(pix_x), 5);
    chk("collision_pix_y", 32'(pix_y), 5);

    step(1, 0, 0, 0, 3'b000, 0, 3'b000);
    chk("toggle_valid_1a", 32'(pix_valid), 1);
    step(0, 0, 0, 0, 3'b000, 0, 3'b000);
    chk("toggle_valid_0", 32'(pix_valid), 0);
    step(1, 0, 0, 0, 3'b000, 0, 3'b000);
    chk("toggle_valid_1b", 32'(pix_valid), 1);
    chk("toggle_pix_x", 32'(pix_x), 7);

    guard = 0;
    while (!(ex == 5 && ey == 5) && guard < 20000) begin
      step(1, 0, 0, 0, 3'b000, 0, 3'b000);
      guard++;
    end
    step(1, 0, 0, 0, 3'b000, 0, 3'b000);
    chk("collision_new_colour", 32'(pix_colour), 32'h3);
    chk("frame2_scan_errors", 32'(scan_err), 0);

    // Asynchronous reset in the middle of a clear while scanning.
    check_en = 0;
    step(1, 0, 0, 0, 3'b000, 1, 3'b101);
    tb_clearing = 1;
    for (int i = 0; i < 50; i++) step(1, 0, 0, 0, 3'b000, 0, 3'b000);
    chk("pre_reset_busy", 32'(clear_busy), 1);
    chk("pre_reset_valid", 32'(pix_valid), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midclear_rst_busy", 32'(clear_busy), 0);
    chk("midclear_rst_valid", 32'(pix_valid), 0);
    chk("midclear_rst_pix_x", 32'(pix_x), 0);
    chk("midclear_rst_pix_y", 32'(pix_y), 0);
    chk("midclear_rst_colour", 32'(pix_colour), 0);
    chk("midclear_rst_frame_start", 32'(frame_start), 0);
    chk("midclear_rst_line_end", 32'(line_end), 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(3);
    chk("post_reset_busy", 32'(clear_busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pixel_framebuffer.md
Name: pixel_framebuffer

Overview:
Receiving end of the pixel-plot interface driven by the circle, fill and line drawers (vga_x/vga_y/vga_colour/vga_plot). It stores plotted pixels in a 160x120x3-bit on-chip framebuffer. A raster scanout port streams the stored image, one pixel per enabled cycle, to the display or a checker. A clear-screen engine fills the whole buffer with one colour on request.

Parameters:
SCREEN_W, 160, pixels per line
SCREEN_H, 120, lines per frame
COLOUR_W, 3, bits per pixel

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
vga_x  input  8  plot x coordinate
vga_y  input  7  plot y coordinate
vga_colour  input  3  plot colour
vga_plot  input  1  write strobe, one pixel per cycle while high
clear_req  input  1  pulse: start full-screen clear
clear_colour  input  3  fill colour, sampled on accepted clear_req
clear_busy  output  1  high while clear in progress
scan_en  input  1  advance scanout by one pixel
pix_x  output  8  x of pix_colour
pix_y  output  7  y of pix_colour
pix_colour  output  3  stored colour at (pix_x, pix_y)
pix_valid  output  1  pix_* valid this cycle
frame_start  output  1  high with pixel (0,0)
line_end  output  1  high with pixel x=159

Behaviour:
- Reset values: clear_busy=0, pix_x=0, pix_y=0, pix_colour=0, pix_valid=0, frame_start=0, line_end=0. Scan counters=0. FSM=IDLE. Memory contents are not reset; software issues a clear after reset.
- Address = y*160 + x, computed as (y<<7)+(y<<5)+x, 15 bits. Depth 19200.
- Write port (single): the IDLE FSM state selects the plot interface. CLEAR selects the clear engine.
- Plot: in IDLE, vga_plot=1 with x<160 and y<120 writes vga_colour at the rising edge. Out-of-range coordinates are silently dropped. Plots during CLEAR are dropped.
- FSM states:
  - IDLE: clear_req=1 -> CLEAR. Latch clear_colour. clr_addr=0. clear_busy=1 from the next cycle.
  - CLEAR: write the latched colour at clr_addr, one address per cycle. At clr_addr=19199, write and go to IDLE. clear_busy falls the cycle after the last write, exactly 19200 cycles after entry. clear_req in CLEAR is ignored.
- Reset mid-clear: immediate return to IDLE with clear_busy=0. The partially cleared buffer is left as is.
- Scanout:
  - Counters sx (0..159) and sy (0..119) address the read port.
  - When scan_en=1, issue a read and advance sx. Wrap sx 159->0 with sy+1. Wrap sy 119->0 after (159,119).
  - scan_en=0 holds the counters. pix_valid=0 on the next cycle.
  - Read latency is 1 cycle. pix_valid, pix_x, pix_y, frame_start and line_end are registered alongside the data, so they describe the pixel read on the previous enabled cycle.
- Read and write are independent and may happen in the same cycle. A same-address collision returns the old data (read-before-write).
- Scanout does not pause during CLEAR.

Decomposition:
- Package vga_pkg holds:
  - SCREEN_W, SCREEN_H and FB_DEPTH=19200
  - typedef colour_t (logic [2:0]) and the coordinate typedefs x_t [7:0] and y_t [6:0]
  - enum fb_state_t {IDLE, CLEAR}
  - function fb_addr(x, y)
- One sub-module, fb_ram: a simple dual-port RAM, 19200x3, with one synchronous write port and one registered read port (read-before-write), inferable as block RAM.

Test Plan:
- Reset: assert rst_n=0 mid-operation -> all outputs 0 and clear_busy=0 in the same cycle, without waiting for a clock edge.
- Clear: clear_req with clear_colour=3'b000 -> clear_busy high for exactly 19200 cycles. A full scanout frame then returns 0 at all 19200 pixels. frame_start is high once and line_end 120 times.
- Plot: after clearing to 000, plot (80,60) with colour 3'b010 -> scanout gives 010 at (80,60) and 000 at (79,60), (81,60), (80,59) and (80,61).
- Boundaries:
  - plots at (160,0) and (0,120) with colour 111 -> ignored; a full-frame scan shows no 111 anywhere.
  - plot (159,119) with colour 101 -> that is the last pixel of the frame, with line_end=1, and the next pixel has frame_start=1 at (0,0).
- Busy drop: during a clear to 000, plot (10,10) with colour 110 -> dropped; (10,10) reads 000 after the clear. A second clear_req during busy does not extend busy past 19200 cycles.
- Collision: same cycle, write 011 to (5,5) while scanout reads (5,5) which holds 000 -> pix_colour=000 this frame and 011 next frame. With scan_en toggling 1,0,1, pix_valid follows one cycle later as 1,0,1.
